rvfi_commit_sequencer: RTL

//  Serialises the NrCommitPorts-wide RVFI commit bus into one in-order record stream for a

---
 rtl/rvfi_commit_sequencer_if.sv | 52 +++++
 rtl/rvfi_commit_sequencer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/rvfi_commit_sequencer_if.sv
// RVFI record type and the commit-bus / trace-sink bundle of rvfi_commit_sequencer.
// Defining RVFI_SEQ_TIMESTAMP_EN adds the per-record stamp_o signal.
package rvfi_seq_pkg;
  typedef struct packed {
    logic        valid;
    logic        trap;
    logic [63:0] pc_rdata;
    logic [31:0] insn;
  } rvfi_instr_t;
endpackage

interface rvfi_commit_sequencer_if #(
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned DEPTH         = 16
);
  localparam int unsigned PW = (NrCommitPorts > 1) ? $clog2(NrCommitPorts) : 1;
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  rvfi_seq_pkg::rvfi_instr_t [NrCommitPorts-1:0] rvfi_i;
  logic                      drain_i;
  rvfi_seq_pkg::rvfi_instr_t trace_o;
  logic [PW-1:0]             trace_port_o;
  logic                      trace_valid_o;
  logic                      trace_ready_i;
  logic [LW-1:0]             level_o;
  logic                      overflow_o;
  logic [31:0]               drop_cnt_o;
  logic                      done_o;
`ifdef RVFI_SEQ_TIMESTAMP_EN
  logic [63:0]               stamp_o;

  modport slave (
    input  rvfi_i, drain_i, trace_ready_i,
    output trace_o, trace_port_o, trace_valid_o, level_o, overflow_o, drop_cnt_o, done_o,
           stamp_o
  );
  modport master (
    output rvfi_i, drain_i, trace_ready_i,
    input  trace_o, trace_port_o, trace_valid_o, level_o, overflow_o, drop_cnt_o, done_o,
           stamp_o
  );
`else
  modport slave (
    input  rvfi_i, drain_i, trace_ready_i,
    output trace_o, trace_port_o, trace_valid_o, level_o, overflow_o, drop_cnt_o, done_o
  );
  modport master (
    output rvfi_i, drain_i, trace_ready_i,
    input  trace_o, trace_port_o, trace_valid_o, level_o, overflow_o, drop_cnt_o, done_o
  );
`endif
endinterface

// File: rtl/rvfi_commit_sequencer.sv
// Serialises the multi-port RVFI commit bus into one in-order record stream via a FIFO,
// with all-or-nothing admission, drop accounting and an end-of-test drain. Macro: RVFI_SEQ_TIMESTAMP_EN.
//
// state    | meaning
// ST_RUN   | capture qualifying commits into the FIFO
// ST_DRAIN | captures ignored, FIFO emptied by the sink
// ST_DONE  | FIFO empty after drain, done_o high until drain_i drops
module rvfi_commit_sequencer #(
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned DEPTH         = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  rvfi_commit_sequencer_if.slave bus
);
  import rvfi_seq_pkg::*;

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned PW = (NrCommitPorts > 1) ? $clog2(NrCommitPorts) : 1;
  localparam int unsigned NW = $clog2(NrCommitPorts + 1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_e;

  state_e                   state_q, state_d;
  rvfi_instr_t              mem_q      [DEPTH];
  logic [PW-1:0]            port_mem_q [DEPTH];
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]            level_q, level_d, free;
  logic                     overflow_q, overflow_d, done_q, done_d;
  logic [31:0]              drop_cnt_q, drop_cnt_d;
  logic [32:0]              drop_sum;
  logic [NrCommitPorts-1:0] qual;
  logic [AW-1:0]            slot [NrCommitPorts];
  logic [NW-1:0]            n_qual;
  logic                     head_valid, pop, accept, push, drop;

  // Qualifying ports are packed into consecutive slots in ascending port order.
  always_comb begin
    qual   = '0;
    slot   = '{default: '0};
    n_qual = '0;
    for (int i = 0; i < NrCommitPorts; i++) begin
      qual[i] = bus.rvfi_i[i].valid | bus.rvfi_i[i].trap;
      slot[i] = wr_ptr_q + AW'(n_qual);
      n_qual  = n_qual + NW'(qual[i]);
    end
  end

  always_comb begin
    head_valid = (level_q != '0);
    pop        = head_valid && bus.trace_ready_i;
    free       = LW'(DEPTH) - level_q + LW'(pop);
    accept     = (state_q == ST_RUN) && (n_qual != '0);
    push       = accept && (LW'(n_qual) <= free);
    drop       = accept && (LW'(n_qual) > free);

    wr_ptr_d   = push ? wr_ptr_q + AW'(n_qual) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q + (push ? LW'(n_qual) : LW'(0)) - LW'(pop);

    drop_sum   = {1'b0, drop_cnt_q} + 33'(n_qual);
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (drop) begin
      drop_cnt_d = drop_sum[32] ? '1 : drop_sum[31:0];
      overflow_d = 1'b1;
    end

    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (bus.drain_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!bus.drain_i)         state_d = ST_RUN;
        else if (level_d == '0)   state_d = ST_DONE;
      end
      ST_DONE:  if (!bus.drain_i) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      done_q     <= done_d;
    end
  end

  // Storage needs no reset: only slots below level_q are ever presented.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NrCommitPorts; i++) begin
      if (push && qual[i]) begin
        mem_q[slot[i]]      <= bus.rvfi_i[i];
        port_mem_q[slot[i]] <= PW'(i);
      end
    end
  end

  assign bus.trace_valid_o = head_valid;
  assign bus.trace_o       = head_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.trace_port_o  = head_valid ? port_mem_q[rd_ptr_q] : '0;
  assign bus.level_o       = level_q;
  assign bus.overflow_o    = overflow_q;
  assign bus.drop_cnt_o    = drop_cnt_q;
  assign bus.done_o        = done_q;

`ifdef RVFI_SEQ_TIMESTAMP_EN
  logic [63:0] cycle_q;
  logic [63:0] stamp_mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cycle_q <= '0;
    else         cycle_q <= cycle_q + 64'd1;
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NrCommitPorts; i++) begin
      if (push && qual[i]) stamp_mem_q[slot[i]] <= cycle_q;
    end
  end

  assign bus.stamp_o = head_valid ? stamp_mem_q[rd_ptr_q] : '0;
`endif
endmodule
